// File: rtl/mips_bus_arbiter.sv
// Two-master round-robin arbiter for the Avalon-style CPU memory bus; the grant is held for one transfer.
// Optional stall timeout with a sticky bus_err flag is built only when ARB_TIMEOUT_EN is defined.
module mips_bus_arbiter #(
  parameter int ADDR_W         = 32,
  parameter int DATA_W         = 32,
  parameter int RESET_PRIO     = 0,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [ADDR_W-1:0]   m0_address,
  input  logic                m0_read,
  input  logic                m0_write,
  input  logic [DATA_W-1:0]   m0_writedata,
  input  logic [DATA_W/8-1:0] m0_byteenable,
  output logic                m0_waitrequest,
  output logic [DATA_W-1:0]   m0_readdata,
  input  logic [ADDR_W-1:0]   m1_address,
  input  logic                m1_read,
  input  logic                m1_write,
  input  logic [DATA_W-1:0]   m1_writedata,
  input  logic [DATA_W/8-1:0] m1_byteenable,
  output logic                m1_waitrequest,
  output logic [DATA_W-1:0]   m1_readdata,
  output logic [ADDR_W-1:0]   s_address,
  output logic                s_read,
  output logic                s_write,
  output logic [DATA_W-1:0]   s_writedata,
  output logic [DATA_W/8-1:0] s_byteenable,
  input  logic                s_waitrequest,
  input  logic [DATA_W-1:0]   s_readdata,
  output logic [1:0]          grant,
  output logic                bus_err
);

  localparam int BE_W = DATA_W / 8;
  localparam logic [DATA_W-1:0] ERR_DATA = DATA_W'({(DATA_W + 31) / 32{32'hDEADBEEF}});

  // One-hot encoding doubles as the registered grant vector {m1,m0}.
  typedef enum logic [1:0] {
    IDLE = 2'b00,
    GNT0 = 2'b01,
    GNT1 = 2'b10
  } state_t;

  state_t            state, state_next;
  logic              last_grant;  // 1: m1 was granted most recently
  logic              req0, req1;
  logic              sel_read, sel_write, stalled, done, timeout_hit;
  logic [ADDR_W-1:0] sel_address;
  logic [DATA_W-1:0] sel_writedata;
  logic [BE_W-1:0]   sel_byteenable;

  assign req0 = m0_read | m0_write;
  assign req1 = m1_read | m1_write;

  // NOTE: every output of a combinational block gets a default first, so no path can infer a latch.
  always_comb begin
    sel_address    = '0;
    sel_read       = 1'b0;
    sel_write      = 1'b0;
    sel_writedata  = '0;
    sel_byteenable = '0;
    case (state)
      GNT0: begin
        sel_address    = m0_address;
        sel_read       = m0_read;
        sel_write      = m0_write;
        sel_writedata  = m0_writedata;
        sel_byteenable = m0_byteenable;
      end
      GNT1: begin
        sel_address    = m1_address;
        sel_read       = m1_read;
        sel_write      = m1_write;
        sel_writedata  = m1_writedata;
        sel_byteenable = m1_byteenable;
      end
      default: ;
    endcase
  end

  assign stalled = (sel_read | sel_write) & s_waitrequest;
  assign done    = (sel_read | sel_write) & ~s_waitrequest;

`ifdef ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] stall_cnt;

  // The limit is reached on the stalled cycle that would make the count equal TIMEOUT_CYCLES.
  assign timeout_hit = stalled && (stall_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_cnt <= '0;
      bus_err   <= 1'b0;
    end else begin
      stall_cnt <= (stalled && state_next == state) ? stall_cnt + 1'b1 : '0;
      if (timeout_hit) bus_err <= 1'b1;
    end
  end
`else
  assign timeout_hit = 1'b0;
  assign bus_err     = 1'b0;
`endif

  assign s_address      = sel_address;
  assign s_read         = sel_read & ~timeout_hit;
  assign s_write        = sel_write & ~timeout_hit;
  assign s_writedata    = sel_writedata;
  assign s_byteenable   = sel_byteenable;
  assign m0_waitrequest = (state == GNT0) ? (s_waitrequest & ~timeout_hit) : 1'b1;
  assign m1_waitrequest = (state == GNT1) ? (s_waitrequest & ~timeout_hit) : 1'b1;
  assign m0_readdata    = timeout_hit ? ERR_DATA : s_readdata;
  assign m1_readdata    = timeout_hit ? ERR_DATA : s_readdata;
  assign grant          = state;

  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (req0 && (!req1 || last_grant)) state_next = GNT0;
        else if (req1)                     state_next = GNT1;
      end
      GNT0: begin
        if (timeout_hit || !req0) state_next = IDLE;
        else if (done)            state_next = req1 ? GNT1 : IDLE;
      end
      GNT1: begin
        if (timeout_hit || !req1) state_next = IDLE;
        else if (done)            state_next = req0 ? GNT0 : IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // NOTE: registers use non-blocking assignments so every flop samples pre-edge values.
  // NOTE: reset is asynchronous, so strobes and grant drop the moment reset goes low.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      last_grant <= (RESET_PRIO == 0);
    end else begin
      state <= state_next;
      if (state_next == GNT0)      last_grant <= 1'b0;
      else if (state_next == GNT1) last_grant <= 1'b1;
    end
  end

endmodule

// File: tb/tb_mips_bus_arbiter.sv
// Self-checking bench for mips_bus_arbiter: vector table, directed corner sequences,
// and randomized traffic compared against a transaction-level reference model.
module tb_mips_bus_arbiter;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int BE_W   = DATA_W / 8;
  localparam int RP     = 0;
`ifdef ARB_TIMEOUT_EN
  localparam bit TO_EN  = 1'b1;
  localparam int TO     = 8;
`else
  localparam bit TO_EN  = 1'b0;
  localparam int TO     = 1024;
`endif
  localparam logic [DATA_W-1:0] ERR = 32'hDEADBEEF;

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic [ADDR_W-1:0] m0_address = '0, m1_address = '0, s_address;
  logic              m0_read = 0, m0_write = 0, m1_read = 0, m1_write = 0;
  logic [DATA_W-1:0] m0_writedata = '0, m1_writedata = '0, s_writedata;
  logic [BE_W-1:0]   m0_byteenable = '0, m1_byteenable = '0, s_byteenable;
  logic              m0_waitrequest, m1_waitrequest, s_read, s_write;
  logic [DATA_W-1:0] m0_readdata, m1_readdata;
  logic              s_waitrequest = 1'b0;
  logic [DATA_W-1:0] s_readdata = '0;
  logic [1:0]        grant;
  logic              bus_err;

  int checks = 0;
  int failures = 0;

  mips_bus_arbiter #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .RESET_PRIO(RP), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk), .reset(reset),
    .m0_address(m0_address), .m0_read(m0_read), .m0_write(m0_write),
    .m0_writedata(m0_writedata), .m0_byteenable(m0_byteenable),
    .m0_waitrequest(m0_waitrequest), .m0_readdata(m0_readdata),
    .m1_address(m1_address), .m1_read(m1_read), .m1_write(m1_write),
    .m1_writedata(m1_writedata), .m1_byteenable(m1_byteenable),
    .m1_waitrequest(m1_waitrequest), .m1_readdata(m1_readdata),
    .s_address(s_address), .s_read(s_read), .s_write(s_write),
    .s_writedata(s_writedata), .s_byteenable(s_byteenable),
    .s_waitrequest(s_waitrequest), .s_readdata(s_readdata),
    .grant(grant), .bus_err(bus_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: who owns the bus, who was served last, stall length, sticky error.
  typedef struct {
    int o;      // -1 idle, else granted master
    int last;
    int cnt;
    bit err;
  } mstate_t;

  mstate_t ms;

  function automatic bit m_req(int i);
    return (i == 0) ? (m0_read | m0_write) : (m1_read | m1_write);
  endfunction

  function automatic bit model_timeout(mstate_t s);
    return TO_EN && s.o >= 0 && m_req(s.o) && s_waitrequest && s.cnt == TO - 1;
  endfunction

  function automatic mstate_t model_step(mstate_t s);
    mstate_t n = s;
    n.cnt = 0;
    if (s.o < 0) begin
      if (m_req(0) && m_req(1)) n.o = 1 - s.last;
      else if (m_req(0))        n.o = 0;
      else if (m_req(1))        n.o = 1;
    end else if (model_timeout(s)) begin
      n.o = -1;
      n.err = 1'b1;
    end else if (!m_req(s.o)) begin
      n.o = -1;
    end else if (!s_waitrequest) begin
      n.o = m_req(1 - s.o) ? 1 - s.o : -1;
    end else begin
      n.cnt = s.cnt + 1;
    end
    if (n.o >= 0) n.last = n.o;
    return n;
  endfunction

  always @(posedge clk or negedge reset) begin
    if (!reset) ms <= '{o: -1, last: 1 - RP, cnt: 0, err: 1'b0};
    else        ms <= model_step(ms);
  end

  task automatic check_model();
    bit to;
    to = model_timeout(ms);
    check("rnd_bus_err", bus_err, ms.err);
    if (ms.o < 0) begin
      check("rnd_grant_idle", grant, 2'b00);
      check("rnd_s_read_idle", s_read, 1'b0);
      check("rnd_s_write_idle", s_write, 1'b0);
      check("rnd_w0_idle", m0_waitrequest, 1'b1);
      check("rnd_w1_idle", m1_waitrequest, 1'b1);
    end else if (ms.o == 0) begin
      check("rnd_grant0", grant, 2'b01);
      check("rnd_s_read0", s_read, m0_read & ~to);
      check("rnd_s_write0", s_write, m0_write & ~to);
      check("rnd_s_addr0", s_address, m0_address);
      check("rnd_s_wdata0", s_writedata, m0_writedata);
      check("rnd_s_be0", s_byteenable, m0_byteenable);
      check("rnd_w0", m0_waitrequest, to ? 1'b0 : s_waitrequest);
      check("rnd_w1_blocked", m1_waitrequest, 1'b1);
      check("rnd_rdata0", m0_readdata, to ? ERR : s_readdata);
    end else begin
      check("rnd_grant1", grant, 2'b10);
      check("rnd_s_read1", s_read, m1_read & ~to);
      check("rnd_s_write1", s_write, m1_write & ~to);
      check("rnd_s_addr1", s_address, m1_address);
      check("rnd_s_wdata1", s_writedata, m1_writedata);
      check("rnd_s_be1", s_byteenable, m1_byteenable);
      check("rnd_w1", m1_waitrequest, to ? 1'b0 : s_waitrequest);
      check("rnd_w0_blocked", m0_waitrequest, 1'b1);
      check("rnd_rdata1", m1_readdata, to ? ERR : s_readdata);
    end
  endtask

  task automatic idle_inputs();
    m0_read = 0; m0_write = 0; m1_read = 0; m1_write = 0;
    s_waitrequest = 0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0;
    idle_inputs();
    #1;
    check("rst_grant", grant, 2'b00);
    check("rst_strobes", {s_read, s_write}, 2'b00);
    check("rst_s_addr", s_address, '0);
    check("rst_s_wdata_be", {s_writedata, s_byteenable}, '0);
    check("rst_waits", {m1_waitrequest, m0_waitrequest}, 2'b11);
    check("rst_bus_err", bus_err, 1'b0);
    @(negedge clk);
    reset = 1'b1;
  endtask

  typedef struct {
    bit r0, w0, r1, w1, sw;
    logic [1:0] grant;
    bit wr0, wr1, sr, swr;
  } vec_t;

  vec_t vecs[13];

  initial begin
    vecs[0]  = '{0,0,0,0,0, 2'b00, 1,1, 0,0};
    vecs[1]  = '{1,0,0,1,1, 2'b00, 1,1, 0,0};  // tie seen in IDLE
    vecs[2]  = '{1,0,0,1,1, 2'b01, 1,1, 1,0};  // m0 wins first tie
    vecs[3]  = '{1,0,0,1,0, 2'b01, 0,1, 1,0};  // m0 completes
    vecs[4]  = '{1,0,0,1,0, 2'b10, 1,0, 0,1};  // back-to-back m1
    vecs[5]  = '{0,0,0,0,0, 2'b01, 0,1, 0,0};  // m0 abandons its grant
    vecs[6]  = '{1,0,0,0,0, 2'b00, 1,1, 0,0};
    vecs[7]  = '{1,0,0,0,0, 2'b01, 0,1, 1,0};
    vecs[8]  = '{1,0,0,0,0, 2'b00, 1,1, 0,0};  // bubble before re-grant
    vecs[9]  = '{0,0,0,0,0, 2'b01, 0,1, 0,0};
    vecs[10] = '{0,0,0,1,0, 2'b00, 1,1, 0,0};
    vecs[11] = '{0,0,1,1,1, 2'b10, 1,1, 1,1};  // read+write forwarded
    vecs[12] = '{0,0,1,1,0, 2'b10, 1,0, 1,1};
  end

  initial begin
    int stall_n;
    do_reset();

    // Vector table
    m0_address = 32'h100;
    m1_address = 32'h200;
    for (int i = 0; i < 13; i++) begin
      @(negedge clk);
      {m0_read, m0_write, m1_read, m1_write, s_waitrequest} =
        {vecs[i].r0, vecs[i].w0, vecs[i].r1, vecs[i].w1, vecs[i].sw};
      #1;
      check($sformatf("vec%0d_grant", i), grant, vecs[i].grant);
      check($sformatf("vec%0d_waits", i), {m0_waitrequest, m1_waitrequest},
            {vecs[i].wr0, vecs[i].wr1});
      check($sformatf("vec%0d_strobes", i), {s_read, s_write}, {vecs[i].sr, vecs[i].swr});
    end

    // Single read with two wait states
    do_reset();
    @(negedge clk);
    m0_read = 1; m0_address = 32'hBFC00000; s_waitrequest = 1;
    #1 check("rd_req_cycle_grant", grant, 2'b00);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk); #1;
      check("rd_stall_grant", grant, 2'b01);
      check("rd_stall_w0", m0_waitrequest, 1'b1);
      check("rd_stall_w1", m1_waitrequest, 1'b1);
      check("rd_s_addr", s_address, 32'hBFC00000);
      check("rd_s_read", s_read, 1'b1);
    end
    @(negedge clk);
    s_waitrequest = 0; s_readdata = 32'h24020005;
    #1;
    check("rd_done_w0", m0_waitrequest, 1'b0);
    check("rd_done_w1", m1_waitrequest, 1'b1);
    check("rd_rdata", m0_readdata, 32'h24020005);
    @(negedge clk);
    m0_read = 0;
    #1;
    check("rd_after_grant", grant, 2'b00);
    check("rd_after_w0", m0_waitrequest, 1'b1);

    // Simultaneous first requests after reset
    do_reset();
    @(negedge clk);
    m0_read = 1; m0_address = 32'h1000;
    m1_write = 1; m1_address = 32'h1000; m1_writedata = 32'hCAFEF00D; m1_byteenable = 4'b0110;
    #1 check("sim_idle_grant", grant, 2'b00);
    @(negedge clk); #1;
    check("sim_m0_grant", grant, 2'b01);
    check("sim_m0_strobes", {s_read, s_write}, 2'b10);
    check("sim_m0_w0", m0_waitrequest, 1'b0);
    @(negedge clk);
    m0_read = 0;
    #1;
    check("sim_m1_grant", grant, 2'b10);
    check("sim_m1_strobes", {s_read, s_write}, 2'b01);
    check("sim_m1_wdata", s_writedata, 32'hCAFEF00D);
    check("sim_m1_be", s_byteenable, 4'b0110);
    check("sim_m1_addr", s_address, 32'h1000);
    check("sim_m1_w1", m1_waitrequest, 1'b0);
    @(negedge clk);
    m1_write = 0;

    // Round-robin fairness, zero-wait slave
    do_reset();
    @(negedge clk);
    m0_read = 1; m1_read = 1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk); #1;
      check($sformatf("rr_grant%0d", i), grant, (i % 2 == 0) ? 2'b01 : 2'b10);
    end

    // Stall isolation
    stall_n = TO_EN ? 5 : 20;
    do_reset();
    @(negedge clk);
    m0_read = 1; m1_read = 1; s_waitrequest = 1;
    for (int i = 0; i < stall_n; i++) begin
      @(negedge clk); #1;
      check("iso_grant", grant, 2'b01);
      check("iso_w1", m1_waitrequest, 1'b1);
    end
    @(negedge clk);
    s_waitrequest = 0;
    #1 check("iso_done_w0", m0_waitrequest, 1'b0);
    @(negedge clk);
    m0_read = 0;
    #1;
    check("iso_m1_grant", grant, 2'b10);
    check("iso_m1_w1", m1_waitrequest, 1'b0);

    // Asynchronous reset during a stalled m1 write
    do_reset();
    @(negedge clk);
    m1_write = 1; s_waitrequest = 1;
    @(negedge clk); #1;
    check("arst_pre_grant", grant, 2'b10);
    check("arst_pre_write", s_write, 1'b1);
    reset = 1'b0;
    #1;
    check("arst_s_write", s_write, 1'b0);
    check("arst_grant", grant, 2'b00);
    check("arst_waits", {m1_waitrequest, m0_waitrequest}, 2'b11);
    @(negedge clk);
    reset = 1'b1;
    idle_inputs();

`ifdef ARB_TIMEOUT_EN
    do_reset();
    @(negedge clk);
    m0_read = 1; s_waitrequest = 1;
    for (int i = 1; i <= TO; i++) begin
      @(negedge clk); #1;
      if (i < TO) begin
        check("to_stall_w0", m0_waitrequest, 1'b1);
        check("to_stall_err", bus_err, 1'b0);
      end else begin
        check("to_hit_w0", m0_waitrequest, 1'b0);
        check("to_hit_rdata", m0_readdata, ERR);
        check("to_hit_s_read", s_read, 1'b0);
      end
    end
    @(negedge clk);
    m0_read = 0;
    #1;
    check("to_after_grant", grant, 2'b00);
    check("to_err_set", bus_err, 1'b1);
    repeat (3) @(negedge clk);
    #1 check("to_err_sticky", bus_err, 1'b1);
`endif

    // Randomized traffic against the reference model
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      m0_read       = ($urandom_range(0, 3) != 0) ? 1'($urandom) : 1'b0;
      m0_write      = ($urandom_range(0, 3) == 0);
      m1_read       = ($urandom_range(0, 3) != 0) ? 1'($urandom) : 1'b0;
      m1_write      = ($urandom_range(0, 3) == 0);
      m0_address    = $urandom;
      m1_address    = $urandom;
      m0_writedata  = $urandom;
      m1_writedata  = $urandom;
      m0_byteenable = BE_W'($urandom);
      m1_byteenable = BE_W'($urandom);
      s_waitrequest = ($urandom_range(0, 9) < 6);
      s_readdata    = $urandom;
      #1 check_model();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
